// File: rtl/ibex_rf_leak_tx_pkg.sv
// Shared types and helpers for the register-file Hamming-weight trace.
package ibex_rf_leak_pkg;

  localparam int unsigned RecWidth = 32;

  // One trace record as seen by the off-core receiver.
  typedef struct packed {
    logic [7:0] seq;
    logic [4:0] addr;
    logic [5:0] hw;
    logic [5:0] hd;
    logic [5:0] rsvd;
    logic       ovf;
  } rec_t;

  function automatic logic [5:0] popcount32(logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'b0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/ibex_rf_leak_tx_if.sv
// Record stream towards the trace receiver (valid/ready, no bypass).
interface ibex_rf_leak_tx_if;
  import ibex_rf_leak_pkg::*;

  logic                rec_valid;
  logic                rec_ready;
  logic [RecWidth-1:0] rec_data;

  modport master (output rec_valid, output rec_data, input rec_ready);
  modport slave  (input rec_valid, input rec_data, output rec_ready);
endinterface

// File: rtl/ibex_rf_leak_fifo.sv
// Synchronous record FIFO; head is presented combinationally, 0 when empty.
module ibex_rf_leak_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  // Extra MSB on each pointer separates full (MSBs differ) from empty.
  logic [AddrW:0]              wr_q, wr_d, rd_q, rd_d;
  logic [Depth-1:0][Width-1:0] mem_q;
  logic                        push_ok, pop_ok;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AddrW] != rd_q[AddrW]) &&
                   (wr_q[AddrW-1:0] == rd_q[AddrW-1:0]);
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign rdata_o = empty_o ? '0 : mem_q[rd_q[AddrW-1:0]];

  // Pointer advance.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_ok) wr_d = wr_q + 1'b1;
    if (pop_ok)  rd_d = rd_q + 1'b1;
  end

  // Pointer and storage registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (push_ok) mem_q[wr_q[AddrW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/ibex_rf_leak_tx.sv
// Taps the RF write port, builds HW/HD records and streams them out.
// Purely observational: when the FIFO is full, records are dropped, not stalled.
module ibex_rf_leak_tx
  import ibex_rf_leak_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned FifoDepth = 8,
  parameter logic [31:0] RegMask   = 32'hFFFF_FFFE
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 we_a_i,
  input  logic [4:0]           waddr_a_i,
  input  logic [DataWidth-1:0] wdata_a_i,
  input  logic                 dummy_instr_wb_i,
  ibex_rf_leak_tx_if.master    rec,
  output logic [15:0]          drop_cnt_o,
  output logic                 fifo_empty_o,
  output logic                 fifo_full_o
);

  logic [DataWidth-1:0] prev_q, prev_d;
  logic [7:0]           seq_q, seq_d;
  logic                 ovf_pend_q, ovf_pend_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;

  logic qual, pop, accept, drop;
  rec_t rec_new;

  assign qual   = en_i & we_a_i & ~dummy_instr_wb_i & RegMask[waddr_a_i];
  assign pop    = rec.rec_valid & rec.rec_ready;
  assign accept = qual & (~fifo_full_o | pop);
  assign drop   = qual & fifo_full_o & ~pop;

  // Record assembly from the current write and the previous traced value.
  always_comb begin
    rec_new      = '0;
    rec_new.seq  = seq_q;
    rec_new.addr = waddr_a_i;
    rec_new.hw   = popcount32(32'(wdata_a_i));
    rec_new.hd   = popcount32(32'(wdata_a_i ^ prev_q));
    rec_new.ovf  = ovf_pend_q;
  end

  // Capture state: prev/seq advance on every qualifying write, dropped or not.
  always_comb begin
    prev_d     = prev_q;
    seq_d      = seq_q;
    ovf_pend_d = ovf_pend_q;
    drop_cnt_d = drop_cnt_q;
    if (qual) begin
      prev_d = wdata_a_i;
      seq_d  = seq_q + 8'd1;
    end
    if (accept) ovf_pend_d = 1'b0;
    if (drop) begin
      ovf_pend_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // Capture state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q     <= '0;
      seq_q      <= '0;
      ovf_pend_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      prev_q     <= prev_d;
      seq_q      <= seq_d;
      ovf_pend_q <= ovf_pend_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  ibex_rf_leak_fifo #(
    .Width (RecWidth),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (accept),
    .wdata_i (rec_new),
    .pop_i   (pop),
    .rdata_o (rec.rec_data),
    .empty_o (fifo_empty_o),
    .full_o  (fifo_full_o)
  );

  assign rec.rec_valid = ~fifo_empty_o;
  assign drop_cnt_o    = drop_cnt_q;

endmodule
